// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI-side schedulers in the pclk domain:
//   transfer-FSM state encoding, default transfer width and a small
//   modular-increment helper used by the round-robin search.
// ---------------------------------------------------------------------------
package spi_pkg;

   localparam int DW_DEFAULT = 8;

   // Transfer scheduler states
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LAUNCH    = 3'd1;
   localparam logic [2:0] ST_WAIT_DONE = 3'd2;
   localparam logic [2:0] ST_RESP      = 3'd3;
   localparam logic [2:0] ST_GAP       = 3'd4;

   // (base + step) mod n, for base < n and step <= n
   function automatic int unsigned wrap_add(input int unsigned base,
                                            input int unsigned step,
                                            input int unsigned n);
      int unsigned sum;
      sum = base + step;
      if (sum >= n) sum = sum - n;
      return sum;
   endfunction

endpackage

// File: rtl/spi_xfer_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin first-set search. Starting at (ptr+1) mod NREQ
//   and moving upward with wrap-around, returns the first index whose request
//   bit is set.
//   Ports:
//     req    in   NREQ  request vector
//     ptr    in   PW    index granted last (search starts just above it)
//     idx    out  PW    selected index (0 when valid is low)
//     valid  out  1     at least one request bit set
// ---------------------------------------------------------------------------
module rr_pick
   import spi_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [PW-1:0]   idx,
   output logic            valid
);

   // cand_idx[gi] is the index examined at search position gi (0 = highest
   // priority); hit[gi] says whether that candidate is requesting.
   logic [PW-1:0] cand_idx [NREQ];
   logic [NREQ-1:0] hit;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_cand
         assign cand_idx[gi] = PW'(wrap_add(int'(ptr), gi + 1, NREQ));
         assign hit[gi]      = req[cand_idx[gi]];
      end
   endgenerate

   // Scan from lowest priority to highest so the highest-priority hit is the
   // last one written and therefore wins.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (hit[k]) begin
            idx   = cand_idx[k];
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// ---------------------------------------------------------------------------
// spi_xfer_arbiter
//   Round-robin scheduler sharing one SPI master datapath among NREQ
//   requesters. Picks a pending request, issues a one-cycle send_data pulse
//   with the requester's byte, waits for the master's receive-done pulse (or
//   an abort when the master is disabled), acknowledges the winner with the
//   received byte, then holds an idle gap of GAP_CYC cycles.
//   Ports:
//     pclk, preset_n  clock / asynchronous active-low reset
//     spi_en_i        master enabled and usable
//     req_i           per-requester level request, held until ack
//     wdata_i         per-requester transmit byte, slice i at [i*DW +: DW]
//     gnt_o           one-hot grant, LAUNCH through RESP
//     ack_o           one-hot one-cycle completion pulse
//     err_o           with ack_o: transfer aborted
//     rdata_o         received byte, valid with ack_o, held until next ack
//     send_data_o     one-cycle start pulse to the SPI master
//     mosi_data_o     transmit byte, stable while the transfer runs
//     miso_data_i     master receive shift register contents
//     r_data_i        master receive-done pulse
//     busy_o          scheduler not idle
// ---------------------------------------------------------------------------
module spi_xfer_arbiter
   import spi_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DW      = DW_DEFAULT,
   parameter int GAP_CYC = 2
) (
   input  logic               pclk,
   input  logic               preset_n,
   input  logic               spi_en_i,
   input  logic [NREQ-1:0]    req_i,
   input  logic [NREQ*DW-1:0] wdata_i,
   output logic [NREQ-1:0]    gnt_o,
   output logic [NREQ-1:0]    ack_o,
   output logic               err_o,
   output logic [DW-1:0]      rdata_o,
   output logic               send_data_o,
   output logic [DW-1:0]      mosi_data_o,
   input  logic [DW-1:0]      miso_data_i,
   input  logic               r_data_i,
   output logic               busy_o
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

   logic [2:0]      state_reg;
   logic [PW-1:0]   idx_reg;
   logic [PW-1:0]   ptr_reg;
   logic [GW-1:0]   gap_cnt_reg;
   logic [NREQ-1:0] gnt_reg;
   logic [NREQ-1:0] ack_reg;
   logic            err_reg;
   logic [DW-1:0]   rdata_reg;
   logic            send_reg;
   logic [DW-1:0]   mosi_reg;

   logic [PW-1:0]   pick_idx;
   logic            pick_valid;
   logic [DW-1:0]   wdata_arr [NREQ];

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_slice
         assign wdata_arr[gi] = wdata_i[gi*DW +: DW];
      end
   endgenerate

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .req   (req_i),
      .ptr   (ptr_reg),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_reg   <= ST_IDLE;
         idx_reg     <= '0;
         ptr_reg     <= PW'(NREQ - 1);
         gap_cnt_reg <= '0;
         gnt_reg     <= '0;
         ack_reg     <= '0;
         err_reg     <= 1'b0;
         rdata_reg   <= '0;
         send_reg    <= 1'b0;
         mosi_reg    <= '0;
      end else begin
         // Pulse outputs default low; only the entering transition raises them.
         send_reg <= 1'b0;
         ack_reg  <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (spi_en_i && pick_valid) begin
                  idx_reg   <= pick_idx;
                  ptr_reg   <= pick_idx;
                  gnt_reg   <= NREQ'(1) << pick_idx;
                  mosi_reg  <= wdata_arr[pick_idx];
                  send_reg  <= 1'b1;
                  state_reg <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               state_reg <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               // Receive-done takes precedence over a simultaneous disable.
               if (r_data_i) begin
                  rdata_reg <= miso_data_i;
                  err_reg   <= 1'b0;
                  ack_reg   <= NREQ'(1) << idx_reg;
                  state_reg <= ST_RESP;
               end else if (!spi_en_i) begin
                  err_reg   <= 1'b1;
                  ack_reg   <= NREQ'(1) << idx_reg;
                  state_reg <= ST_RESP;
               end
            end
            ST_RESP: begin
               gnt_reg     <= '0;
               err_reg     <= 1'b0;
               gap_cnt_reg <= GW'(GAP_CYC - 1);
               state_reg   <= ST_GAP;
            end
            ST_GAP: begin
               if (gap_cnt_reg == '0) begin
                  state_reg <= ST_IDLE;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - 1'b1;
               end
            end
            default: begin
               gnt_reg   <= '0;
               err_reg   <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt_o       = gnt_reg;
   assign ack_o       = ack_reg;
   assign err_o       = err_reg;
   assign rdata_o     = rdata_reg;
   assign send_data_o = send_reg;
   assign mosi_data_o = mosi_reg;
   assign busy_o      = (state_reg != ST_IDLE);

endmodule

// File: doc/spi_xfer_arbiter.md
# spi_xfer_arbiter

Round-robin transfer scheduler that shares the single APB-SPI master datapath among several on-chip requesters. It picks one pending request and drives the one-cycle `send_data` start pulse and transmit byte into the SPI master (slave-select / baud / shifter path). It then waits for the master's receive-done pulse, returns the received byte and an acknowledge to the winning requester, and enforces an idle gap before the next transfer. It sits between the requester clients and the SPI master core, inside the pclk domain.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 8, transfer data width
- GAP_CYC, 2, minimum idle pclk cycles between transfers (>=1)
- pclk  in  1  APB clock; all logic on rising edge
- preset_n  in  1  reset, asynchronous, active-low
- spi_en_i  in  1  master enabled and not in wait mode (mstr & !spiswai & mode 00/01)
- req_i  in  NREQ  per-requester transfer request, level, held until ack
- wdata_i  in  NREQ*DW  per-requester transmit byte, slice i = wdata_i[i*DW +: DW]
- gnt_o  out  NREQ  one-hot grant, high from LAUNCH through RESP
- ack_o  out  NREQ  one-hot, one-cycle completion pulse
- err_o  out  1  qualifies ack_o: transfer aborted
- rdata_o  out  DW  received byte, valid with ack_o, held until next ack
- send_data_o  out  1  one-cycle start pulse to SPI master
- mosi_data_o  out  DW  transmit byte to master, held stable LAUNCH..WAIT_DONE
- miso_data_i  in  DW  master's receive-shift-register contents
- r_data_i  in  1  master receive-done pulse (one cycle)
- busy_o  out  1  high in every state except IDLE

## Operation
- Reset values: gnt_o=0, ack_o=0, err_o=0, rdata_o=0, send_data_o=0, mosi_data_o=0, busy_o=0, state=IDLE, rr pointer=NREQ-1.
- FSM: IDLE -> LAUNCH -> WAIT_DONE -> RESP -> GAP -> IDLE.
- IDLE: if spi_en_i && |req_i, select the first set req_i index searching upward from (ptr+1) mod NREQ. Register the index, set gnt_o, latch mosi_data_o from the corresponding wdata_i slice, update ptr to the index, and go to LAUNCH.
- LAUNCH (1 cycle): send_data_o=1, then go to WAIT_DONE.
- WAIT_DONE:
  - on r_data_i, capture miso_data_i into rdata_o, err_o=0, go to RESP;
  - else if !spi_en_i, rdata_o unchanged, err_o=1, go to RESP (abort).
- RESP (1 cycle): ack_o[idx]=1, gnt_o still asserted; gnt_o clears on exit. err_o is valid only while ack_o is high and is 0 otherwise.
- GAP: count GAP_CYC cycles with gnt_o=0, then go to IDLE. New requests are not sampled in GAP.
- Requests dropped before grant are ignored. req_i/wdata_i changes after grant have no effect. A requester must deassert req_i the cycle after ack or it re-enters arbitration.
- r_data_i outside WAIT_DONE is ignored.
- Gap counter width: clog2(GAP_CYC+1). Pointer width: clog2(NREQ).

## Timing
- Request in IDLE at edge N -> gnt_o high after N, send_data_o high cycle N+1 only.
- r_data_i sampled at edge M -> ack_o/rdata_o valid in cycle M+1 -> gnt_o low at M+2 -> earliest next send_data_o at M+3+GAP_CYC.
- Simultaneous r_data_i and !spi_en_i in WAIT_DONE: r_data_i wins (err_o=0).
- spi_en_i low in IDLE: no grant; pending requests wait, priority unchanged.
- Async reset mid-transfer: all outputs return to reset values immediately; no ack is issued for the interrupted transfer; ptr resets.

## Structure
- Shared package `spi_pkg`: FSM state encoding (IDLE, LAUNCH, WAIT_DONE, RESP, GAP), default DW.
- One sub-module: `rr_pick` (combinational round-robin first-set search given req vector and pointer, outputs index and valid), reusable by other SPI-side schedulers.

## Test plan
- Single request: req_i=4'b0010, wdata slice1=8'hA5, r_data_i 20 cycles after send, miso=8'h3C -> one send_data_o pulse with mosi=8'hA5; ack_o=4'b0010, rdata_o=8'h3C, err_o=0.
- Fairness: req_i=4'b1111 held, each dropped one cycle after its ack -> grant order 0,1,2,3 from reset; the next round with 4'b1001 gives 0 then 3.
- Abort: spi_en_i falls in WAIT_DONE -> ack with err_o=1, rdata_o keeps the previous value, then GAP.
- Collision: r_data_i and spi_en_i fall on the same edge -> err_o=0, data captured.
- Gap enforcement with GAP_CYC=2: back-to-back requests -> at least 3 cycles between ack_o and the next send_data_o; stray r_data_i in IDLE/GAP has no effect.
- Reset in WAIT_DONE: gnt_o=0, busy_o=0 immediately; no ack_o; the first post-reset grant goes to the lowest pending index.
